mod_seq_checker: RTL
====================

# mod_seq_checker

Downstream monitor for the MOD-N counter stage. It samples the counter's K-bit output every clock and checks that the value advances by exactly one and wraps from N-1 to 0. It reports completed wraps and sequence errors, and drives a registered 7-segment display of the current count. It sits directly on the counter's output bus, in the same clock domain.

## Interface
- K, 4, width of the monitored count bus (K ≥ 4)
- N, 10, modulus of the monitored counter (2 ≤ N ≤ 2^K)
- W, 8, width of the wrap and error event counters
- CLK  input  1  rising-edge clock shared with the counter
- RST  input  1  reset; synchronous, active-high, highest priority
- count_in  input  K  counter value, sampled every rising edge
- clr  input  1  synchronous clear of error state and event counters
- wrap_pulse  output  1  one-cycle pulse per valid N-1 → 0 wrap
- wrap_cnt  output  W  number of valid wraps, saturating
- locked  output  1  high while the checker is in CHECK
- err  output  1  sticky sequence-error flag
- err_cnt  output  W  number of mismatching samples, saturating
- seg  output  7  active-low segments {g,f,e,d,c,b,a} for count_in[3:0]

## Operation
- State register `prev[K-1:0]` holds the last sampled count_in. It updates every cycle in all states except under RST or clr.
- Expected value is exp = (prev == N-1) ? 0 : prev + 1.
  - Compute exp at K+1 bits so that N = 2^K does not overflow.
- Mismatch means count_in ≠ exp, or count_in ≥ N.
  - A held value (count_in == prev) is a mismatch; the counter has no enable.
- FSM states: ACQ, CHECK, ERR.
  - ACQ: loads prev, performs no comparison, and moves to CHECK next cycle.
  - CHECK on a match: stays in CHECK. If prev == N-1 and count_in == 0, it pulses wrap_pulse and increments wrap_cnt.
  - CHECK on a mismatch: moves to ERR, sets err, and increments err_cnt.
  - ERR: err stays high and locked stays low. Each further mismatch increments err_cnt. No wraps are counted. The FSM leaves ERR only via clr or RST.
- clr (any state): next state ACQ; err, err_cnt and wrap_cnt go to 0; wrap_pulse goes to 0; prev is not loaded that cycle.
- Counters saturate at 2^W-1 and never roll over.
- seg decodes count_in[3:0] as hex 0–F using the standard active-low pattern, for example 0 → 7'b1000000 and 1 → 7'b1111001.
- Reset values: state ACQ, prev 0, wrap_pulse 0, wrap_cnt 0, locked 0, err 0, err_cnt 0, seg 7'b1111111 (blank).

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- The sample on edge t drives outputs valid after edge t+1 (1-cycle latency) for wrap_pulse, wrap_cnt, err, err_cnt and seg.
- locked rises one cycle after the ACQ sample, i.e. on the second edge after RST or clr is released.
- wrap_pulse is exactly one cycle wide. With a free-running MOD-N counter it repeats every N cycles.
- Priority order is RST > clr > FSM update.
  - If clr and a mismatch occur in the same cycle, clr wins: err = 0, err_cnt = 0.
- If a mismatch coincides with the cycle where err_cnt is at maximum, err_cnt holds at max and err stays 1.
- If RST is asserted mid-sequence, all state returns to reset values on the next edge. The first comparison happens two edges after RST is released.
- If the upstream counter is held in reset while the checker runs, count_in stays 0. This produces a mismatch every cycle: ERR is entered and err_cnt increments each cycle until saturation.

## Test plan
All scenarios use K=4, N=10, W=8.
- Reset then free run: release RST, drive 0,1,…,9,0,1,… → locked = 1 from the second edge; err = 0; wrap_pulse high one cycle after each 9 → 0 sample; wrap_cnt = 3 after three wraps; seg = 7'b0010000 one cycle after count_in = 9.
- Skip error: in sequence 3,4,6,7 → err = 1 and err_cnt = 1 one cycle after the 6; locked = 0; continuing 8,9,0 adds no wraps and err_cnt stays 1.
- Out-of-range and hold: in CHECK drive 5, then 12 (0xC), then 12 → ERR entered on the 12, err_cnt = 2; seg shows C = 7'b1000110.
- Clear recovery: in ERR with err_cnt = 5, pulse clr for one cycle, then resume a valid sequence → err = 0, err_cnt = 0, wrap_cnt = 0 after clr; locked = 1 two edges after clr is released.
- Simultaneous clr and mismatch: drive a mismatch in the same cycle clr = 1 → state ACQ, err = 0, err_cnt = 0.
- Saturation and reset mid-run: hold count_in = 0 for 300 cycles → err_cnt = 255 and does not roll over; assert RST for one cycle → all outputs at reset values, seg = 7'b1111111.

Source files
------------

// File: rtl/mod_seq_checker.sv
// Sequence checker for a MOD-N counter bus: flags skips, holds and out-of-range values,
// counts valid wraps and errors (saturating), and drives a registered 7-segment view of the count.
module mod_seq_checker #(
   parameter int unsigned K = 4,
   parameter int unsigned N = 10,
   parameter int unsigned W = 8
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic [K-1:0] count_in,
   input  logic         clr,
   output logic         wrap_pulse,
   output logic [W-1:0] wrap_cnt,
   output logic         locked,
   output logic         err,
   output logic [W-1:0] err_cnt,
   output logic [6:0]   seg
);

   localparam logic [K-1:0] LAST    = K'(N - 1);
   localparam logic [K:0]   N_EXT   = (K + 1)'(N);
   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
   localparam logic [6:0]   SEG_OFF = 7'b1111111;

   typedef enum logic [1:0] {ACQ, CHECK, ERR} state_e;

   state_e       state_q, state_d;
   logic [K-1:0] prev_q, prev_d;
   logic         wrap_pulse_q, wrap_pulse_d;
   logic [W-1:0] wrap_cnt_q, wrap_cnt_d;
   logic         locked_q, locked_d;
   logic         err_q, err_d;
   logic [W-1:0] err_cnt_q, err_cnt_d;
   logic [6:0]   seg_q, seg_d;

   logic [K:0]   exp_c;
   logic         mismatch_c;

   // Active-low {g,f,e,d,c,b,a} hex digit patterns
   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Expected successor is one bit wider so that N == 2^K cannot overflow
   always_comb begin
      exp_c      = (prev_q == LAST) ? '0 : ({1'b0, prev_q} + (K + 1)'(1));
      mismatch_c = ({1'b0, count_in} != exp_c) || ({1'b0, count_in} >= N_EXT);
   end

   always_comb begin
      state_d      = state_q;
      prev_d       = count_in;
      wrap_pulse_d = 1'b0;
      wrap_cnt_d   = wrap_cnt_q;
      err_d        = err_q;
      err_cnt_d    = err_cnt_q;
      seg_d        = hex_to_seg(count_in[3:0]);

      case (state_q)
         ACQ: state_d = CHECK;
         CHECK: begin
            if (mismatch_c) begin
               state_d = ERR;
               err_d   = 1'b1;
               if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + W'(1);
            end else if ((prev_q == LAST) && (count_in == '0)) begin
               wrap_pulse_d = 1'b1;
               if (wrap_cnt_q != CNT_MAX) wrap_cnt_d = wrap_cnt_q + W'(1);
            end
         end
         ERR: begin
            if (mismatch_c && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + W'(1);
         end
         default: state_d = ACQ;
      endcase

      // Clear overrides whatever the FSM decided this cycle
      if (clr) begin
         state_d      = ACQ;
         prev_d       = prev_q;
         wrap_pulse_d = 1'b0;
         wrap_cnt_d   = '0;
         err_d        = 1'b0;
         err_cnt_d    = '0;
      end

      // Locked only once a CHECK cycle has been survived, so it rises one cycle after ACQ
      locked_d = (state_q == CHECK) && (state_d == CHECK);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= ACQ;
         prev_q       <= '0;
         wrap_pulse_q <= 1'b0;
         wrap_cnt_q   <= '0;
         locked_q     <= 1'b0;
         err_q        <= 1'b0;
         err_cnt_q    <= '0;
         seg_q        <= SEG_OFF;
      end else begin
         state_q      <= state_d;
         prev_q       <= prev_d;
         wrap_pulse_q <= wrap_pulse_d;
         wrap_cnt_q   <= wrap_cnt_d;
         locked_q     <= locked_d;
         err_q        <= err_d;
         err_cnt_q    <= err_cnt_d;
         seg_q        <= seg_d;
      end
   end

   assign wrap_pulse = wrap_pulse_q;
   assign wrap_cnt   = wrap_cnt_q;
   assign locked     = locked_q;
   assign err        = err_q;
   assign err_cnt    = err_cnt_q;
   assign seg        = seg_q;

endmodule
